// File: rtl/narrow_axi_mem_responder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// narrow_axi_mem_responder_pkg : AXI channel types, encodings, beat address helper
// Revision: 1.0
// ----------------------------------------------------------------------------
package narrow_axi_mem_responder_pkg;

  localparam int unsigned AddrWidth    = 48;
  localparam int unsigned AxiDataWidth = 64;
  localparam int unsigned IdWidth      = 4;
  localparam int unsigned StrbWidth    = AxiDataWidth / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    WRESP = 2'd2,
    READ  = 2'd3
  } state_e;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic [5:0]           atop;
  } aw_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } ar_chan_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0] data;
    logic [StrbWidth-1:0]    strb;
    logic                    last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]      id;
    logic [AxiDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_rsp_t;

  // INCR realigns to the beat size before stepping; FIXED and WRAP hold the address.
  function automatic logic [AddrWidth-1:0] beat_next_addr(input logic [AddrWidth-1:0] addr,
                                                          input logic [2:0]           size,
                                                          input logic [1:0]           burst);
    logic [AddrWidth-1:0] step;
    step = AddrWidth'(1) << size;
    if (burst == BURST_INCR) begin
      return (addr & ~(step - AddrWidth'(1))) + step;
    end
    return addr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/narrow_axi_mem_responder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// narrow_axi_mem_responder_if : narrow AXI request/response bundle
// Revision: 1.0
// ----------------------------------------------------------------------------
interface narrow_axi_mem_responder_if;
  import narrow_axi_mem_responder_pkg::*;

  axi_req_t req;
  axi_rsp_t rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);
endinterface
`default_nettype wire

// File: rtl/narrow_axi_mem_responder_addr_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// narrow_axi_mem_responder_addr_gen : per-beat address, counter, range/error flags
// Revision: 1.0
// ----------------------------------------------------------------------------
module narrow_axi_mem_responder_addr_gen
  import narrow_axi_mem_responder_pkg::*;
#(
  parameter int unsigned          DataWidth = AxiDataWidth,
  parameter int unsigned          NumWords  = 1024,
  parameter logic [AddrWidth-1:0] BaseAddr  = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        load_i,
  input  logic [AddrWidth-1:0]        addr_i,
  input  logic [7:0]                  len_i,
  input  logic [2:0]                  size_i,
  input  logic [1:0]                  burst_i,
  input  logic                        advance_i,
  output logic [$clog2(NumWords)-1:0] index_o,
  output logic                        last_o,
  output logic                        err_o
);

  localparam int unsigned OffBits = $clog2(DataWidth / 8);
  localparam int unsigned IdxBits = $clog2(NumWords);
  localparam logic [AddrWidth:0] MemBytes = (AddrWidth + 1)'(NumWords * (DataWidth / 8));

  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [7:0]           beat_q, beat_d;
  logic [7:0]           len_q, len_d;
  logic [2:0]           size_q, size_d;
  logic [1:0]           burst_q, burst_d;
  logic [AddrWidth:0]   offset;

  always_comb begin
    addr_d  = addr_q;
    beat_d  = beat_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    if (load_i) begin
      addr_d  = addr_i;
      beat_d  = '0;
      len_d   = len_i;
      size_d  = size_i;
      burst_d = burst_i;
    end else if (advance_i) begin
      addr_d = beat_next_addr(addr_q, size_q, burst_q);
      beat_d = beat_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      beat_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
    end else begin
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
    end
  end

  // Addresses below the base wrap to a huge offset, so one compare covers both bounds.
  assign offset  = {1'b0, addr_q} - {1'b0, BaseAddr};
  assign index_o = offset[OffBits +: IdxBits];
  assign last_o  = (beat_q == len_q);
  assign err_o   = (offset >= MemBytes) || (burst_q == BURST_WRAP);

endmodule
`default_nettype wire

// File: rtl/narrow_axi_mem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// narrow_axi_mem_responder : single-transaction AXI4 subordinate over a register-file memory
// Revision: 1.0
// ----------------------------------------------------------------------------
module narrow_axi_mem_responder
  import narrow_axi_mem_responder_pkg::*;
#(
  parameter int unsigned          DataWidth = AxiDataWidth,
  parameter int unsigned          NumWords  = 1024,
  parameter logic [AddrWidth-1:0] BaseAddr  = '0
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  narrow_axi_mem_responder_if.slave        axi_io,
  output logic                             busy_o
);

  localparam int unsigned IdxBits = $clog2(NumWords);
  localparam int unsigned StrbW   = DataWidth / 8;

  state_e             state_q, state_d;
  logic [IdWidth-1:0] id_q, id_d;
  logic               err_q, err_d;
  logic               noop_q, noop_d;
  logic               last_rd_q, last_rd_d;
  logic [DataWidth-1:0] mem_q [NumWords];

  axi_req_t             req;
  axi_rsp_t             rsp;
  logic                 sel_aw, sel_ar;
  logic                 ag_load, ag_adv, ag_last, ag_err, mem_we;
  logic [IdxBits-1:0]   ag_index;
  logic [AddrWidth-1:0] ag_addr;
  logic [7:0]           ag_len;
  logic [2:0]           ag_size;
  logic [1:0]           ag_burst;

  assign req        = axi_io.req;
  assign axi_io.rsp = rsp;
  assign busy_o     = (state_q != IDLE);

  // Round-robin tie break: a read wins a collision unless it won the previous grant.
  assign sel_ar = rst_ni && (state_q == IDLE) && req.ar_valid && (!req.aw_valid || !last_rd_q);
  assign sel_aw = rst_ni && (state_q == IDLE) && req.aw_valid && !sel_ar;

  assign ag_load  = sel_aw || sel_ar;
  assign ag_addr  = sel_ar ? req.ar.addr  : req.aw.addr;
  assign ag_len   = sel_ar ? req.ar.len   : req.aw.len;
  assign ag_size  = sel_ar ? req.ar.size  : req.aw.size;
  assign ag_burst = sel_ar ? req.ar.burst : req.aw.burst;

  narrow_axi_mem_responder_addr_gen #(
    .DataWidth (DataWidth),
    .NumWords  (NumWords),
    .BaseAddr  (BaseAddr)
  ) u_addr_gen (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (ag_load),
    .addr_i    (ag_addr),
    .len_i     (ag_len),
    .size_i    (ag_size),
    .burst_i   (ag_burst),
    .advance_i (ag_adv),
    .index_o   (ag_index),
    .last_o    (ag_last),
    .err_o     (ag_err)
  );

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    err_d        = err_q;
    noop_d       = noop_q;
    last_rd_d    = last_rd_q;
    ag_adv       = 1'b0;
    mem_we       = 1'b0;
    rsp          = '0;
    rsp.aw_ready = sel_aw;
    rsp.ar_ready = sel_ar;
    case (state_q)
      IDLE: begin
        if (sel_ar) begin
          state_d   = READ;
          id_d      = req.ar.id;
          last_rd_d = 1'b1;
        end else if (sel_aw) begin
          state_d   = WRITE;
          id_d      = req.aw.id;
          err_d     = (req.aw.atop != '0);
          noop_d    = (req.aw.atop != '0);
          last_rd_d = 1'b0;
        end
      end
      WRITE: begin
        rsp.w_ready = 1'b1;
        if (req.w_valid) begin
          ag_adv = 1'b1;
          mem_we = rst_ni && !ag_err && !noop_q;
          if (ag_err || (req.w.last != ag_last)) err_d = 1'b1;
          if (req.w.last || ag_last) state_d = WRESP;
        end
      end
      WRESP: begin
        rsp.b_valid = 1'b1;
        rsp.b.id    = id_q;
        rsp.b.resp  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (req.b_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
          noop_d  = 1'b0;
        end
      end
      READ: begin
        rsp.r_valid = 1'b1;
        rsp.r.id    = id_q;
        rsp.r.last  = ag_last;
        rsp.r.resp  = ag_err ? RESP_SLVERR : RESP_OKAY;
        rsp.r.data  = ag_err ? '0 : mem_q[ag_index];
        if (req.r_ready) begin
          ag_adv = 1'b1;
          if (ag_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      id_q      <= '0;
      err_q     <= 1'b0;
      noop_q    <= 1'b0;
      last_rd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      err_q     <= err_d;
      noop_q    <= noop_d;
      last_rd_q <= last_rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < StrbW; b++) begin
        if (req.w.strb[b]) mem_q[ag_index][8*b +: 8] <= req.w.data[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_narrow_axi_mem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_narrow_axi_mem_responder : randomized bench against a word-array reference model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_narrow_axi_mem_responder;
  import narrow_axi_mem_responder_pkg::*;

  localparam int unsigned NW   = 1024;
  localparam logic [47:0] BASE = 48'h1000;
  localparam int unsigned MEMB = NW * 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  narrow_axi_mem_responder_if bus();

  narrow_axi_mem_responder #(
    .DataWidth (64),
    .NumWords  (NW),
    .BaseAddr  (BASE)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .axi_io (bus),
    .busy_o (busy)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] mdl   [NW];
  logic [63:0] wdata [256];
  logic [7:0]  wstrb [256];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Beat j of a burst: INCR beats after the first sit on size-aligned slots.
  function automatic logic [47:0] beat_addr(input logic [47:0] a, input logic [2:0] size,
                                            input logic [1:0] burst, input int j);
    longint unsigned aa, step;
    aa   = 64'(a);
    step = 64'd1 << size;
    if (burst != BURST_INCR || j == 0) return a;
    return 48'((aa / step) * step + 64'(j) * step);
  endfunction

  function automatic logic beat_ok(input logic [47:0] a, input logic [1:0] burst);
    longint unsigned aa;
    aa = 64'(a);
    return (aa >= 64'(BASE)) && (aa < 64'(BASE) + 64'(MEMB)) && (burst != BURST_WRAP);
  endfunction

  function automatic int widx(input logic [47:0] a);
    return int'((64'(a) - 64'(BASE)) >> 3);
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [47:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [5:0] atop);
    bus.req.aw       = '{id: id, addr: a, len: len, size: size, burst: burst, atop: atop};
    bus.req.aw_valid = 1'b1;
    #1 check("aw_ready", 128'(bus.rsp.aw_ready), 128'(1));
    @(posedge clk); @(negedge clk);
    bus.req.aw_valid = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [47:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bus.req.ar       = '{id: id, addr: a, len: len, size: size, burst: burst};
    bus.req.ar_valid = 1'b1;
    #1 check("ar_ready", 128'(bus.rsp.ar_ready), 128'(1));
    @(posedge clk); @(negedge clk);
    bus.req.ar_valid = 1'b0;
  endtask

  task automatic send_w(input logic [7:0] len);
    for (int i = 0; i <= int'(len); i++) begin
      bus.req.w       = '{data: wdata[i], strb: wstrb[i], last: (i == int'(len))};
      bus.req.w_valid = 1'b1;
      #1 check("w_ready", 128'(bus.rsp.w_ready), 128'(1));
      @(posedge clk); @(negedge clk);
    end
    bus.req.w_valid = 1'b0;
    bus.req.w.last  = 1'b0;
  endtask

  task automatic recv_b(input logic [3:0] id, input logic [1:0] resp);
    int d;
    d = $urandom_range(0, 2);
    for (int k = 0; k <= d; k++) begin
      bus.req.b_ready = (k == d);
      #1 check("b_chan", 128'({bus.rsp.b_valid, bus.rsp.b.id, bus.rsp.b.resp}),
                         128'({1'b1, id, resp}));
      @(posedge clk); @(negedge clk);
    end
    bus.req.b_ready = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [47:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [5:0] atop);
    logic        err;
    logic [47:0] ba;
    err = (atop != 6'd0);
    send_aw(id, a, len, size, burst, atop);
    send_w(len);
    for (int j = 0; j <= int'(len); j++) begin
      ba = beat_addr(a, size, burst, j);
      if (!beat_ok(ba, burst)) err = 1'b1;
      else if (atop == 6'd0) begin
        for (int b = 0; b < 8; b++) if (wstrb[j][b]) mdl[widx(ba)][8*b +: 8] = wdata[j][8*b +: 8];
      end
    end
    recv_b(id, err ? RESP_SLVERR : RESP_OKAY);
  endtask

  task automatic recv_r(input logic [3:0] id, input logic [47:0] a, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst,
                        input logic [31:0] pat, input int rst_beat);
    int          j, cyc;
    logic [47:0] ba;
    logic        ok, acc;
    logic [63:0] d;
    j   = 0;
    cyc = 0;
    while (j <= int'(len)) begin
      bus.req.r_ready = pat[cyc % 32];
      ba = beat_addr(a, size, burst, j);
      ok = beat_ok(ba, burst);
      d  = 64'h0;
      if (ok) d = mdl[widx(ba)];
      if (j == rst_beat) begin
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        bus.req.r_ready = 1'b0;
        #1 check("rst_mid", 128'({bus.rsp.r_valid, busy}), 128'(0));
        return;
      end
      #1 check("r_beat", 128'({bus.rsp.r_valid, bus.rsp.r.id, bus.rsp.r.resp, bus.rsp.r.last, bus.rsp.r.data}),
                         128'({1'b1, id, ok ? RESP_OKAY : RESP_SLVERR, (j == int'(len)), d}));
      acc = bus.rsp.r_valid && bus.req.r_ready;
      @(posedge clk); @(negedge clk);
      if (acc) j++;
      cyc++;
      if (cyc > 2000) begin
        check("r_timeout", 128'(j), 128'(int'(len) + 1));
        break;
      end
    end
    bus.req.r_ready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [47:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [31:0] pat, input int rst_beat);
    send_ar(id, a, len, size, burst);
    recv_r(id, a, len, size, burst, pat, rst_beat);
  endtask

  initial begin
    logic [7:0]  rlen;
    logic [2:0]  rsz;
    logic [1:0]  rbu;
    logic [47:0] ra;
    logic [3:0]  rid;

    bus.req = '0;
    reset_dut();
    #1 check("reset", 128'({bus.rsp, busy}), 128'(0));

    // Fill the whole memory so every later read has a known model value.
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 256; i++) begin
        wdata[i] = {$urandom, $urandom};
        wstrb[i] = 8'hFF;
      end
      axi_write(4'(blk), BASE + 48'(blk * 2048), 8'd255, 3'd3, BURST_INCR, 6'd0);
    end
    reset_dut();

    // Colliding AW/AR from reset: AR, AW, AR, AW.
    for (int p = 0; p < 2; p++) begin
      wdata[0] = {$urandom, $urandom};
      wstrb[0] = 8'hFF;
      bus.req.aw       = '{id: 4'h5, addr: BASE + 48'h100, len: 8'd0, size: 3'd3, burst: BURST_INCR, atop: 6'd0};
      bus.req.aw_valid = 1'b1;
      bus.req.ar       = '{id: 4'h6, addr: BASE + 48'h100, len: 8'd0, size: 3'd3, burst: BURST_INCR};
      bus.req.ar_valid = 1'b1;
      #1 check("arb_ar_first", 128'({bus.rsp.ar_ready, bus.rsp.aw_ready}), 128'(2'b10));
      @(posedge clk); @(negedge clk);
      bus.req.ar_valid = 1'b0;
      #1 check("aw_blocked", 128'({bus.rsp.aw_ready, busy}), 128'(2'b01));
      recv_r(4'h6, BASE + 48'h100, 8'd0, 3'd3, BURST_INCR, '1, -1);
      axi_write(4'h5, BASE + 48'h100, 8'd0, 3'd3, BURST_INCR, 6'd0);
    end

    // Single write then read.
    wdata[0] = 64'hDEADBEEF_CAFEF00D;
    wstrb[0] = 8'hFF;
    axi_write(4'h3, BASE + 48'h10, 8'd0, 3'd3, BURST_INCR, 6'd0);
    axi_read(4'h3, BASE + 48'h10, 8'd0, 3'd3, BURST_INCR, '1, -1);

    // INCR burst with r_ready toggling.
    for (int i = 0; i < 4; i++) begin
      wdata[i] = 64'(i + 1);
      wstrb[i] = 8'hFF;
    end
    axi_write(4'h1, BASE, 8'd3, 3'd3, BURST_INCR, 6'd0);
    axi_read(4'h2, BASE, 8'd3, 3'd3, BURST_INCR, 32'h5555_5555, -1);

    // Strobed FIXED burst clearing both halves of one word.
    wdata[0] = '1;
    wstrb[0] = 8'hFF;
    axi_write(4'h4, BASE, 8'd0, 3'd3, BURST_INCR, 6'd0);
    wdata[0] = '0; wstrb[0] = 8'h0F;
    wdata[1] = '0; wstrb[1] = 8'hF0;
    axi_write(4'h4, BASE, 8'd1, 3'd3, BURST_FIXED, 6'd0);
    axi_read(4'h4, BASE, 8'd0, 3'd3, BURST_INCR, '1, -1);

    // Range edges, WRAP and atomic writes.
    axi_read(4'h7, BASE + 48'(MEMB) - 48'd8, 8'd1, 3'd3, BURST_INCR, '1, -1);
    axi_read(4'h7, BASE - 48'd8, 8'd1, 3'd3, BURST_INCR, '1, -1);
    for (int i = 0; i < 2; i++) begin
      wdata[i] = {$urandom, $urandom};
      wstrb[i] = 8'hFF;
    end
    axi_write(4'h8, BASE + 48'h40, 8'd1, 3'd3, BURST_WRAP, 6'd0);
    axi_write(4'h9, BASE + 48'h40, 8'd1, 3'd3, BURST_INCR, 6'h20);
    axi_read(4'h9, BASE + 48'h40, 8'd1, 3'd3, BURST_INCR, '1, -1);

    // Randomized bursts, including narrow sizes and beats outside the window.
    for (int t = 0; t < 24; t++) begin
      rlen = 8'($urandom_range(0, 7));
      rsz  = 3'($urandom_range(0, 3));
      rbu  = ($urandom_range(0, 4) == 0) ? BURST_FIXED : BURST_INCR;
      ra   = BASE - 48'd32 + 48'($urandom_range(0, MEMB + 63));
      rid  = 4'($urandom);
      for (int i = 0; i <= int'(rlen); i++) begin
        wdata[i] = {$urandom, $urandom};
        wstrb[i] = 8'($urandom);
      end
      axi_write(rid, ra, rlen, rsz, rbu, 6'd0);
      axi_read(~rid, ra, rlen, rsz, rbu, $urandom | 32'h1111_1111, -1);
    end

    // Reset during beat 2 of a long read, then a normal read.
    axi_read(4'hA, BASE, 8'd7, 3'd3, BURST_INCR, '1, 2);
    axi_read(4'hB, BASE + 48'h80, 8'd0, 3'd3, BURST_INCR, '1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
